// File: rtl/mem_bus_arbiter.sv
// Two-master (IFU, LSU) to one-slave memory port arbiter, one outstanding transaction.
// Define MEM_ARB_PERF_EN to add grant/conflict performance counters. o_dbg_state: 0 IDLE, 1 REQ, 2 RSP.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STARVE_MAX = 4,
    localparam int MASK_W = DATA_W / 8,
    localparam int CNT_W = $clog2(STARVE_MAX + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_ifu_req_valid,
    output logic              o_ifu_req_ready,
    input  logic [ADDR_W-1:0] i_ifu_addr,
    output logic              o_ifu_rsp_valid,
    input  logic              i_ifu_rsp_ready,
    output logic [DATA_W-1:0] o_ifu_rdata,
    input  logic              i_lsu_req_valid,
    output logic              o_lsu_req_ready,
    input  logic [ADDR_W-1:0] i_lsu_addr,
    input  logic              i_lsu_wen,
    input  logic [DATA_W-1:0] i_lsu_wdata,
    input  logic [MASK_W-1:0] i_lsu_wmask,
    output logic              o_lsu_rsp_valid,
    input  logic              i_lsu_rsp_ready,
    output logic [DATA_W-1:0] o_lsu_rdata,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic [MASK_W-1:0] o_mem_wmask,
    input  logic              i_mem_rsp_valid,
    output logic              o_mem_rsp_ready,
    input  logic [DATA_W-1:0] i_mem_rdata,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]       o_perf_ifu_grants,
    output logic [31:0]       o_perf_lsu_grants,
    output logic [31:0]       o_perf_conflict_cycles,
`endif
    output logic [1:0]        o_dbg_state,
    output logic [1:0]        o_dbg_owner,
    output logic [CNT_W-1:0]  o_dbg_starve_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IFU  = 2'd1,
        OWN_LSU  = 2'd2
    } owner_t;

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    state_t            r_state;
    state_t            w_state_next;
    owner_t            r_owner;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_wen;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_wmask;

    logic w_ifu_forced;
    logic w_lsu_wins;
    logic w_lsu_grant;
    logic w_ifu_grant;

    // Every channel transfers on the rising edge where valid && ready are both high;
    // a requester must hold valid and its fields stable until that edge.
    assign w_ifu_forced = i_ifu_req_valid && (r_starve_cnt == STARVE_LIM);
    assign w_lsu_wins   = i_lsu_req_valid && !w_ifu_forced;
    assign w_lsu_grant  = (r_state == S_IDLE) && w_lsu_wins;
    assign w_ifu_grant  = (r_state == S_IDLE) && i_ifu_req_valid && !w_lsu_wins;

    assign o_lsu_req_ready = w_lsu_grant;
    assign o_ifu_req_ready = w_ifu_grant;

    always_comb begin
        w_state_next    = r_state;
        o_mem_req_valid = 1'b0;
        o_mem_rsp_ready = 1'b0;
        o_ifu_rsp_valid = 1'b0;
        o_lsu_rsp_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ifu_grant || w_lsu_grant) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                o_mem_req_valid = 1'b1;
                if (i_mem_req_ready) begin
                    w_state_next = S_RSP;
                end
            end
            S_RSP: begin
                // Response path is a pure pass-through steered by the recorded owner.
                if (r_owner == OWN_LSU) begin
                    o_lsu_rsp_valid = i_mem_rsp_valid;
                    o_mem_rsp_ready = i_lsu_rsp_ready;
                end else if (r_owner == OWN_IFU) begin
                    o_ifu_rsp_valid = i_mem_rsp_valid;
                    o_mem_rsp_ready = i_ifu_rsp_ready;
                end
                if (i_mem_rsp_valid && o_mem_rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_owner      <= OWN_NONE;
            r_starve_cnt <= '0;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_lsu_grant) begin
                r_owner <= OWN_LSU;
                r_addr  <= i_lsu_addr;
                r_wen   <= i_lsu_wen;
                r_wdata <= i_lsu_wdata;
                r_wmask <= i_lsu_wmask;
                if (!i_ifu_req_valid) begin
                    r_starve_cnt <= '0;
                end else if (r_starve_cnt != STARVE_LIM) begin
                    r_starve_cnt <= r_starve_cnt + CNT_W'(1);
                end
            end else if (w_ifu_grant) begin
                r_owner      <= OWN_IFU;
                r_addr       <= i_ifu_addr;
                r_wen        <= 1'b0;
                r_wdata      <= '0;
                r_wmask      <= '0;
                r_starve_cnt <= '0;
            end else if ((r_state == S_RSP) && (w_state_next == S_IDLE)) begin
                r_owner <= OWN_NONE;
            end
        end
    end

    assign o_mem_addr  = r_addr;
    assign o_mem_wen   = r_wen;
    assign o_mem_wdata = r_wdata;
    assign o_mem_wmask = r_wmask;

    assign o_ifu_rdata = i_mem_rdata;
    assign o_lsu_rdata = i_mem_rdata;

    assign o_dbg_state      = r_state;
    assign o_dbg_owner      = r_owner;
    assign o_dbg_starve_cnt = r_starve_cnt;

`ifdef MEM_ARB_PERF_EN
    logic        w_conflict;
    logic [31:0] r_perf_ifu_grants;
    logic [31:0] r_perf_lsu_grants;
    logic [31:0] r_perf_conflict_cycles;

    // A cycle is a conflict whenever both masters want the port and one of them is left waiting.
    assign w_conflict = i_ifu_req_valid && i_lsu_req_valid && !(w_ifu_grant && w_lsu_grant);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_perf_ifu_grants      <= '0;
            r_perf_lsu_grants      <= '0;
            r_perf_conflict_cycles <= '0;
        end else begin
            if (w_ifu_grant) begin
                r_perf_ifu_grants <= r_perf_ifu_grants + 32'd1;
            end
            if (w_lsu_grant) begin
                r_perf_lsu_grants <= r_perf_lsu_grants + 32'd1;
            end
            if (w_conflict) begin
                r_perf_conflict_cycles <= r_perf_conflict_cycles + 32'd1;
            end
        end
    end

    assign o_perf_ifu_grants      = r_perf_ifu_grants;
    assign o_perf_lsu_grants      = r_perf_lsu_grants;
    assign o_perf_conflict_cycles = r_perf_conflict_cycles;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios followed by randomized traffic,
// all checked against a transaction-level model of the arbitration rules.
module tb_mem_bus_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MASK_W     = 4;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = $clog2(STARVE_MAX + 1);
    localparam int TXN_W      = ADDR_W + 1 + DATA_W + MASK_W;
    localparam int ST_IDLE    = 0;
    localparam int ST_RSP     = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [ADDR_W-1:0] ifu_addr;
    logic [DATA_W-1:0] ifu_rdata;
    logic              lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
    logic [MASK_W-1:0] lsu_wmask;
    logic              mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [MASK_W-1:0] mem_wmask;
    logic [1:0]        dbg_state, dbg_owner;
    logic [CNT_W-1:0]  dbg_starve_cnt;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]       perf_ifu_grants, perf_lsu_grants, perf_conflict_cycles;
`endif

    always #5 clock = ~clock;

    mem_bus_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clock(clock), .reset(reset),
        .i_ifu_req_valid(ifu_req_valid), .o_ifu_req_ready(ifu_req_ready), .i_ifu_addr(ifu_addr),
        .o_ifu_rsp_valid(ifu_rsp_valid), .i_ifu_rsp_ready(ifu_rsp_ready), .o_ifu_rdata(ifu_rdata),
        .i_lsu_req_valid(lsu_req_valid), .o_lsu_req_ready(lsu_req_ready), .i_lsu_addr(lsu_addr),
        .i_lsu_wen(lsu_wen), .i_lsu_wdata(lsu_wdata), .i_lsu_wmask(lsu_wmask),
        .o_lsu_rsp_valid(lsu_rsp_valid), .i_lsu_rsp_ready(lsu_rsp_ready), .o_lsu_rdata(lsu_rdata),
        .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready), .o_mem_addr(mem_addr),
        .o_mem_wen(mem_wen), .o_mem_wdata(mem_wdata), .o_mem_wmask(mem_wmask),
        .i_mem_rsp_valid(mem_rsp_valid), .o_mem_rsp_ready(mem_rsp_ready), .i_mem_rdata(mem_rdata),
`ifdef MEM_ARB_PERF_EN
        .o_perf_ifu_grants(perf_ifu_grants), .o_perf_lsu_grants(perf_lsu_grants),
        .o_perf_conflict_cycles(perf_conflict_cycles),
`endif
        .o_dbg_state(dbg_state), .o_dbg_owner(dbg_owner), .o_dbg_starve_cnt(dbg_starve_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transfer, LSU priority, starvation counter.
    bit                m_busy, m_acc, m_owner_lsu, m_wen;
    int                m_starve;
    int                m_ifu_grants, m_lsu_grants, m_conflict;
    logic [TXN_W-1:0]  exp_q[$];
    bit                grant_log[$];
    bit                acc_ifu, acc_lsu;
    bit                exp_order [0:6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_owner_lsu = 0; m_wen = 0; m_starve = 0;
        m_ifu_grants = 0; m_lsu_grants = 0; m_conflict = 0;
        exp_q.delete();
        acc_ifu = 0; acc_lsu = 0;
    endtask

    task automatic idle_inputs();
        ifu_req_valid = 0; ifu_addr = '0;
        lsu_req_valid = 0; lsu_addr = '0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = '0;
        ifu_rsp_ready = 1; lsu_rsp_ready = 1;
    endtask

    // Called just after a falling edge with inputs driven; checks this cycle, then advances one cycle.
    task automatic tick();
        bit lsu_wins, g_i, g_l, own_ready, e_mrv, e_mrr, e_irv, e_lrv;
        logic [TXN_W-1:0] cur;
        #1;
        lsu_wins  = lsu_req_valid && !(ifu_req_valid && (m_starve == STARVE_MAX));
        g_l       = !m_busy && lsu_wins;
        g_i       = !m_busy && ifu_req_valid && !lsu_wins;
        own_ready = m_owner_lsu ? lsu_rsp_ready : ifu_rsp_ready;
        e_mrv     = m_busy && !m_acc;
        e_mrr     = m_busy && m_acc && own_ready;
        e_irv     = m_busy && m_acc && !m_owner_lsu && mem_rsp_valid;
        e_lrv     = m_busy && m_acc && m_owner_lsu && mem_rsp_valid;
        check("ifu_req_ready", ifu_req_ready, g_i);
        check("lsu_req_ready", lsu_req_ready, g_l);
        check("mem_req_valid", mem_req_valid, e_mrv);
        check("mem_rsp_ready", mem_rsp_ready, e_mrr);
        check("ifu_rsp_valid", ifu_rsp_valid, e_irv);
        check("lsu_rsp_valid", lsu_rsp_valid, e_lrv);
        check("starve_cnt", dbg_starve_cnt, m_starve);
        if (e_mrv && exp_q.size() > 0) begin
            cur = exp_q[0];
            check("mem_addr", mem_addr, cur[TXN_W-1 -: ADDR_W]);
            check("mem_wen", mem_wen, cur[DATA_W + MASK_W]);
            check("mem_wmask", mem_wmask, cur[MASK_W-1:0]);
            if (cur[DATA_W + MASK_W]) check("mem_wdata", mem_wdata, cur[MASK_W +: DATA_W]);
        end
        if (e_irv) check("ifu_rdata", ifu_rdata, mem_rdata);
        if (e_lrv && !m_wen) check("lsu_rdata", lsu_rdata, mem_rdata);
        if (ifu_req_valid && lsu_req_valid && !(g_i && g_l)) m_conflict++;
        acc_ifu = g_i;
        acc_lsu = g_l;
        if (g_l || g_i) begin
            m_busy = 1; m_acc = 0; m_owner_lsu = g_l;
            if (g_l) begin
                exp_q.push_back({lsu_addr, lsu_wen, lsu_wdata, lsu_wmask});
                m_wen = lsu_wen;
                m_starve = !ifu_req_valid ? 0 : ((m_starve < STARVE_MAX) ? m_starve + 1 : m_starve);
                m_lsu_grants++;
            end else begin
                exp_q.push_back({ifu_addr, 1'b0, {DATA_W{1'b0}}, {MASK_W{1'b0}}});
                m_wen = 0;
                m_starve = 0;
                m_ifu_grants++;
            end
            grant_log.push_back(g_l);
        end else if (e_mrv && mem_req_ready) begin
            m_acc = 1;
            void'(exp_q.pop_front());
        end else if (e_mrr && mem_rsp_valid) begin
            m_busy = 0;
        end
        @(negedge clock);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int start;
        int n_l;
        idle_inputs();
        model_reset();
        reset = 0;
        #2;
        check("rst_ifu_req_ready", ifu_req_ready, 0);
        check("rst_lsu_req_ready", lsu_req_ready, 0);
        check("rst_mem_req_valid", mem_req_valid, 0);
        check("rst_mem_rsp_ready", mem_rsp_ready, 0);
        check("rst_ifu_rsp_valid", ifu_rsp_valid, 0);
        check("rst_lsu_rsp_valid", lsu_rsp_valid, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wen", mem_wen, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wmask", mem_wmask, 0);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_owner", dbg_owner, 0);
        check("rst_starve", dbg_starve_cnt, 0);
`ifdef MEM_ARB_PERF_EN
        check("rst_perf_ifu", perf_ifu_grants, 0);
        check("rst_perf_lsu", perf_lsu_grants, 0);
        check("rst_perf_conf", perf_conflict_cycles, 0);
`endif
        @(negedge clock);
        @(negedge clock);
        reset = 1;

        // Single IFU read.
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
        #1 check("t1_no_req_yet", mem_req_valid, 0);
        tick();
        ifu_req_valid = 0;
        #1 check("t1_mem_req_valid", mem_req_valid, 1);
        check("t1_mem_addr", mem_addr, 32'h8000_0000);
        tick();
        mem_rsp_valid = 1; mem_rdata = 32'h0000_0413;
        #1 check("t1_ifu_rsp_valid", ifu_rsp_valid, 1);
        check("t1_ifu_rdata", ifu_rdata, 32'h0000_0413);
        check("t1_lsu_rsp_valid", lsu_rsp_valid, 0);
        tick();
        mem_rsp_valid = 0;
        #1 check("t1_back_idle", dbg_state, ST_IDLE);
        idle_inputs();

        // Simultaneous requests: LSU write first, IFU on the next IDLE.
        ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; mem_req_ready = 1;
        #1 check("t2_lsu_ready", lsu_req_ready, 1);
        check("t2_ifu_ready", ifu_req_ready, 0);
        tick();
        lsu_req_valid = 0; lsu_wen = 0;
        #1 check("t2_mem_wen", mem_wen, 1);
        check("t2_mem_wmask", mem_wmask, 4'hF);
        check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("t2_mem_addr", mem_addr, 32'h8000_1000);
        check("t2_ifu_wait", ifu_req_ready, 0);
        tick();
        mem_rsp_valid = 1;
        tick();
        mem_rsp_valid = 0;
        #1 check("t2_ifu_granted", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 0;
        #1 check("t2_ifu_addr", mem_addr, 32'h8000_0004);
        check("t2_ifu_wen", mem_wen, 0);
        check("t2_ifu_wmask", mem_wmask, 0);
        tick();
        mem_rsp_valid = 1;
        tick();
        idle_inputs();

        // Memory stalls on both request and response sides.
        lsu_req_valid = 1; lsu_addr = 32'h8000_3000; lsu_wen = 1;
        lsu_wdata = 32'h1234_5678; lsu_wmask = 4'h3; mem_req_ready = 0; lsu_rsp_ready = 0;
        tick();
        lsu_req_valid = 0; lsu_wdata = $urandom; lsu_addr = $urandom;
        mem_rsp_valid = 1;
        for (int i = 0; i < 5; i++) begin
            #1 check("t4_stall_addr", mem_addr, 32'h8000_3000);
            check("t4_stall_wdata", mem_wdata, 32'h1234_5678);
            check("t4_unsolicited", mem_rsp_ready, 0);
            tick();
        end
        mem_req_ready = 1;
        tick();
        mem_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1 check("t4_rsp_ready_mirror", mem_rsp_ready, 0);
            check("t4_hold_rsp", dbg_state, ST_RSP);
            tick();
        end
        lsu_rsp_ready = 1;
        #1 check("t4_rsp_ready_high", mem_rsp_ready, 1);
        tick();
        mem_rsp_valid = 0;
        #1 check("t4_idle", dbg_state, ST_IDLE);
        idle_inputs();

        // Asynchronous reset while the LSU owns the response phase.
        ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
        lsu_req_valid = 1; lsu_addr = 32'h8000_4000; mem_req_ready = 1;
        tick();
        lsu_req_valid = 0;
        tick();
        mem_rsp_valid = 1; lsu_rsp_ready = 0;
        #1 check("t5_pre_lsu_rsp", lsu_rsp_valid, 1);
        check("t5_pre_starve", dbg_starve_cnt, 1);
        reset = 0;
        #1 check("t5_mem_req_valid", mem_req_valid, 0);
        check("t5_mem_rsp_ready", mem_rsp_ready, 0);
        check("t5_lsu_rsp_valid", lsu_rsp_valid, 0);
        check("t5_state", dbg_state, ST_IDLE);
        check("t5_starve", dbg_starve_cnt, 0);
        idle_inputs();
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1;

        // Starvation: IFU held while the LSU issues six back-to-back reads.
        start = grant_log.size();
        n_l = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
        mem_req_ready = 1; mem_rsp_valid = 1; mem_rdata = 32'hCAFE_0001;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (acc_ifu) ifu_req_valid = 0;
            if (acc_lsu) begin
                n_l++;
                if (n_l == 6) lsu_req_valid = 0;
                else lsu_addr = lsu_addr + 32'd4;
            end
        end
        check("t3_grant_count", grant_log.size() - start, 7);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t3_grant%0d", i),
                  (start + i < grant_log.size()) ? grant_log[start + i] : 1'bx, exp_order[i]);
        end
`ifdef MEM_ARB_PERF_EN
        check("t3_perf_lsu", perf_lsu_grants, 6);
        check("t3_perf_ifu", perf_ifu_grants, 1);
        check("t3_perf_conf_nz", perf_conflict_cycles > 0, 1);
        check("t3_perf_conf", perf_conflict_cycles, m_conflict);
`endif
        idle_inputs();

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            if (!ifu_req_valid || acc_ifu) begin
                ifu_req_valid = ($urandom_range(0, 99) < 40);
                ifu_addr      = $urandom & 32'hFFFF_FFFC;
            end
            if (!lsu_req_valid || acc_lsu) begin
                lsu_req_valid = ($urandom_range(0, 99) < 50);
                lsu_addr      = $urandom;
                lsu_wen       = $urandom_range(0, 1);
                lsu_wdata     = $urandom;
                lsu_wmask     = $urandom_range(0, 15);
            end
            mem_req_ready = ($urandom_range(0, 99) < 60);
            mem_rsp_valid = ($urandom_range(0, 99) < 50);
            mem_rdata     = $urandom;
            ifu_rsp_ready = ($urandom_range(0, 99) < 70);
            lsu_rsp_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
`ifdef MEM_ARB_PERF_EN
        check("end_perf_ifu", perf_ifu_grants, m_ifu_grants);
        check("end_perf_lsu", perf_lsu_grants, m_lsu_grants);
        check("end_perf_conf", perf_conflict_cycles, m_conflict);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
